punc_state_dumper: RTL and testbench
====================================

Name: punc_state_dumper

Overview:
- Downstream consumer of the PUnC LC3 core's debug ports.
- On a start pulse, it sequences the core's debug addresses and collects a snapshot: PC, R0–R7, then a caller-selected memory window.
- It streams the snapshot as tagged 16-bit words over a valid/ready interface to the trace/UART/testbench logic.
- It never stalls the core. Each word reflects core state at the cycle it is captured.

Parameters:
- DATA_W, 16, width of debug data and output words
- ADDR_W, 16, width of memory debug address and window registers
- NUM_REGS, 8, number of register-file entries dumped (rf_debug_addr width = log2(NUM_REGS) = 3)

Ports:
- clk  input  1  clock, same clock as the PUnC core
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE
- mem_base  input  16  first memory address of the window; latched on accepted start
- mem_count  input  16  number of memory words in the window; latched on accepted start; 0 = no memory words
- pc_debug_data  input  16  core PC (combinational from core)
- rf_debug_data  input  16  core RF word at rf_debug_addr (combinational)
- mem_debug_data  input  16  core memory word at mem_debug_addr (combinational)
- rf_debug_addr  output  3  RF index being read
- mem_debug_addr  output  16  memory address being read
- out_valid  output  1  out_data/out_tag/out_last valid
- out_ready  input  1  consumer accepts the word when out_valid && out_ready
- out_data  output  16  snapshot word
- out_tag  output  2  word type: 0 = PC, 1 = RF, 2 = MEM, 3 = reserved (never driven)
- out_last  output  1  final word of the dump
- busy  output  1  high from the accepted start until the last word is accepted
- done  output  1  one-cycle pulse on the cycle after the last word is accepted

Behaviour:
- Reset (synchronous, rst high at a clk edge): state = IDLE.
  - out_valid, out_last, busy, done = 0.
  - out_data = 0, out_tag = 0.
  - rf_debug_addr = 0, mem_debug_addr = 0.
  - Latched base/count = 0.
- Reset asserted mid-dump aborts immediately. No further words, no done pulse.
- States: IDLE, PC, RF, MEM, FIN.
- Item pointer: the debug addresses are always driven from a registered pointer naming the next item to load. The core's debug reads are combinational, so the word is captured into the output register at the loading edge.
- IDLE, start = 1: latch mem_base/mem_count, set busy = 1, load PC word. out_valid = 1 on the next cycle with tag 0. Latency from start to first valid = 1 cycle.
- Output register load rule: it loads the next item when out_valid = 0 or (out_valid && out_ready).
  - With out_ready held high, throughput is 1 word/cycle with no bubbles.
  - While out_valid && !out_ready, out_data, out_tag and out_last are held stable and the pointer does not advance.
- Sequence:
  - PC (1 word).
  - RF indices 0..NUM_REGS-1, tag 1 (8 words).
  - MEM addresses base, base+1, …, base+count-1, tag 2 (count words).
  - Total beats = 9 + mem_count.
- Memory address arithmetic is modulo 2^16. base = 0xFFFF, count = 2 reads 0xFFFF then 0x0000.
- mem_count = 0: the MEM state is skipped and out_last is asserted with R7.
- out_last = 1 only on the final word: the last MEM word, or R7 when count = 0.
- FIN: entered on acceptance of the last word. Next cycle: done = 1, busy = 0, out_valid = 0, then return to IDLE. A new start is accepted the cycle after done.
- start while busy (any state other than IDLE) is ignored. Latched base/count do not change.
- mem_base/mem_count changing mid-dump has no effect.
- The dumper does not require core quiescence. Values are sampled at load time. The consumer may stop the core externally for a coherent snapshot.

Test Plan:
- Reset then idle: rst high 2 cycles.
  - Required: all outputs 0, busy = 0.
  - start held low for 10 cycles keeps out_valid = 0.
- Basic dump: core with PC = 0x3000, Rn = 0x1110*n, mem[0x3000..0x3002] = 0xAAAA/0xBBBB/0xCCCC. Start with base = 0x3000, count = 3, out_ready = 1.
  - Required: 12 consecutive beats: tag0 0x3000, tag1 0x0000…0x7770, tag2 0xAAAA, 0xBBBB, 0xCCCC.
  - out_last on beat 12 only; done 1 cycle later.
- Backpressure: same dump with out_ready toggling 1,0,0,1 repeatedly.
  - Required: data/tag held while stalled, no word dropped or duplicated, still 12 beats.
- Boundaries:
  - count = 0: 9 beats, out_last on R7 (tag 1).
  - base = 0xFFFF, count = 2: mem_debug_addr 0xFFFF then 0x0000.
- Start while busy / reset mid-dump:
  - A second start during beat 5 is ignored (total still 12).
  - rst at beat 6: the next cycle shows out_valid = 0, busy = 0, no done pulse, and a fresh start works afterward.

Source files
------------

// File: rtl/punc_state_dumper.sv
// Snapshot dumper for the PUnC LC3 core debug ports: on start, streams PC, R0..R(NUM_REGS-1)
// and a memory window as tagged words. Latency: first word valid 1 cycle after accepted start.
// Backpressure: output register holds while out_valid && !out_ready; the core is never stalled.
//
// Ports:
//   clk, rst                      clock (core clock), synchronous active-high reset
//   start, mem_base, mem_count    dump request and memory window (latched on accepted start)
//   pc/rf/mem_debug_data          combinational debug reads from the core
//   rf_debug_addr, mem_debug_addr registered item pointer driving the core debug reads
//   out_valid/out_ready/out_data/out_tag/out_last   tagged word stream
//   busy, done                    dump in progress / one-cycle completion pulse
module punc_state_dumper #(
  parameter  int DATA_W   = 16,
  parameter  int ADDR_W   = 16,
  parameter  int NUM_REGS = 8,
  localparam int RF_AW    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] mem_base,
  input  logic [ADDR_W-1:0] mem_count,
  input  logic [DATA_W-1:0] pc_debug_data,
  input  logic [DATA_W-1:0] rf_debug_data,
  input  logic [DATA_W-1:0] mem_debug_data,
  output logic [RF_AW-1:0]  rf_debug_addr,
  output logic [ADDR_W-1:0] mem_debug_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_tag,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0]       TAG_PC  = 2'd0;
  localparam logic [1:0]       TAG_RF  = 2'd1;
  localparam logic [1:0]       TAG_MEM = 2'd2;
  localparam logic [RF_AW-1:0] RF_LAST = RF_AW'(NUM_REGS - 1);

  // State names the category of the next item to load. PC means the PC word
  // sits in the output register and RF index 0 is next.
  typedef enum logic [2:0] {
    IDLE,
    PC,
    RF,
    MEM,
    FIN
  } state_t;

  state_t            state;
  // Remaining memory words to load. Together with mem_debug_addr this is the
  // latched copy of the window, so later changes on mem_base/mem_count are ignored.
  logic [ADDR_W-1:0] mem_left;

  logic accept;
  logic load_ok;

  assign accept  = out_valid && out_ready;
  assign load_ok = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      mem_left       <= '0;
      rf_debug_addr  <= '0;
      mem_debug_addr <= '0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_tag        <= TAG_PC;
      out_last       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mem_debug_addr <= mem_base;
            mem_left       <= mem_count;
            rf_debug_addr  <= '0;
            busy           <= 1'b1;
            out_valid      <= 1'b1;
            out_data       <= pc_debug_data;
            out_tag        <= TAG_PC;
            out_last       <= 1'b0;
            state          <= PC;
          end
        end

        PC, RF: begin
          if (accept && out_last) begin
            // Only reachable with an empty window: R(NUM_REGS-1) was the final word.
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= FIN;
          end else if (load_ok && !out_last) begin
            out_valid <= 1'b1;
            out_data  <= rf_debug_data;
            out_tag   <= TAG_RF;
            out_last  <= (rf_debug_addr == RF_LAST) && (mem_left == '0);
            if (rf_debug_addr == RF_LAST) begin
              // With an empty window stay in RF holding the last word until it drains.
              state <= (mem_left == '0) ? RF : MEM;
            end else begin
              rf_debug_addr <= rf_debug_addr + RF_AW'(1);
              state         <= RF;
            end
          end
        end

        MEM: begin
          if (accept && out_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= FIN;
          end else if (load_ok && !out_last) begin
            out_valid      <= 1'b1;
            out_data       <= mem_debug_data;
            out_tag        <= TAG_MEM;
            out_last       <= (mem_left == ADDR_W'(1));
            mem_left       <= mem_left - ADDR_W'(1);
            // Wraps modulo 2^ADDR_W.
            mem_debug_addr <= mem_debug_addr + ADDR_W'(1);
          end
        end

        FIN: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_punc_state_dumper.sv
module tb_punc_state_dumper;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] mem_base;
  logic [15:0] mem_count;
  logic [15:0] pc_debug_data;
  logic [15:0] rf_debug_data;
  logic [15:0] mem_debug_data;
  logic [2:0]  rf_debug_addr;
  logic [15:0] mem_debug_addr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_tag;
  logic        out_last;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  punc_state_dumper dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .mem_base       (mem_base),
    .mem_count      (mem_count),
    .pc_debug_data  (pc_debug_data),
    .rf_debug_data  (rf_debug_data),
    .mem_debug_data (mem_debug_data),
    .rf_debug_addr  (rf_debug_addr),
    .mem_debug_addr (mem_debug_addr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_tag        (out_tag),
    .out_last       (out_last),
    .busy           (busy),
    .done           (done)
  );

  // Core stand-in: PC = 0x3000, Rn = 0x1110*n, a few known memory words.
  function automatic logic [15:0] mem_model(input logic [15:0] a);
    case (a)
      16'h3000: return 16'hAAAA;
      16'h3001: return 16'hBBBB;
      16'h3002: return 16'hCCCC;
      16'hFFFF: return 16'h1234;
      16'h0000: return 16'h5678;
      default:  return a ^ 16'h5A5A;
    endcase
  endfunction

  assign pc_debug_data  = 16'h3000;
  assign rf_debug_data  = 16'h1110 * {13'd0, rf_debug_addr};
  assign mem_debug_data = mem_model(mem_debug_addr);

  // Expected word k of a dump: PC, then R0..R7, then mem[base+k-9].
  function automatic logic [15:0] exp_word(input int k, input logic [15:0] base);
    logic [15:0] off;
    if (k == 0) return 16'h3000;
    if (k <= 8) begin
      off = 16'(k - 1);
      return 16'h1110 * off;
    end
    off = 16'(k - 9);
    return mem_model(base + off);
  endfunction

  function automatic logic [1:0] exp_tag(input int k);
    if (k == 0) return 2'd0;
    if (k <= 8) return 2'd1;
    return 2'd2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [15:0] base;
    logic [15:0] count;
    int          mode;        // 0: ready always high, 1: ready pattern 1,0,0,1
    int          extra_start; // beat index at which a spurious start is pulsed, -1 none
    int          rst_beat;    // beat index at which reset is asserted, -1 none
    int          exp_beats;
    logic [1:0]  exp_last_tag;
  } vec_t;

  task automatic run_dump(input vec_t v);
    int          beats = 0;
    int          cyc = 0;
    bit          finishing = 0;
    bit          finished = 0;
    bit          sent_extra = 0;
    bit          prev_stall = 0;
    logic [15:0] pd = '0;
    logic [1:0]  pt = '0;
    logic        pl = 1'b0;
    logic [1:0]  last_tag = 2'd3;

    @(negedge clk);
    start     = 1'b1;
    mem_base  = v.base;
    mem_count = v.count;
    out_ready = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    // Changing the window mid-dump must have no effect.
    mem_base  = 16'h5555;
    mem_count = 16'h0007;

    while (cyc < 300 && !finished) begin
      out_ready = (v.mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      start     = 1'b0;
      if (v.extra_start >= 0 && beats == v.extra_start && !sent_extra) begin
        start      = 1'b1;
        sent_extra = 1'b1;
      end
      #1;
      if (cyc == 0) check({v.name, " first valid latency"}, {31'd0, out_valid}, 32'd1);

      if (v.rst_beat >= 0 && beats == v.rst_beat) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check({v.name, " valid after rst"}, {31'd0, out_valid}, 32'd0);
        check({v.name, " busy after rst"}, {31'd0, busy}, 32'd0);
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          #1;
          check({v.name, " no done after rst"}, {30'd0, done, out_valid}, 32'd0);
        end
        return;
      end

      if (finishing) begin
        check({v.name, " done pulse"}, {31'd0, done}, 32'd1);
        check({v.name, " busy low at done"}, {31'd0, busy}, 32'd0);
        check({v.name, " valid low at done"}, {31'd0, out_valid}, 32'd0);
        finished = 1'b1;
      end else begin
        check({v.name, " done low while busy"}, {31'd0, done}, 32'd0);
        check({v.name, " busy"}, {31'd0, busy}, 32'd1);
        if (prev_stall) begin
          check({v.name, " hold valid"}, {31'd0, out_valid}, 32'd1);
          check({v.name, " hold data/tag/last"}, {13'd0, out_data, out_tag, out_last},
                {13'd0, pd, pt, pl});
        end
        prev_stall = out_valid && !out_ready;
        pd = out_data;
        pt = out_tag;
        pl = out_last;
        if (out_valid && out_ready) begin
          check($sformatf("%s beat %0d data", v.name, beats), {16'd0, out_data},
                {16'd0, exp_word(beats, v.base)});
          check($sformatf("%s beat %0d tag", v.name, beats), {30'd0, out_tag},
                {30'd0, exp_tag(beats)});
          check($sformatf("%s beat %0d last", v.name, beats), {31'd0, out_last},
                {31'd0, beats == v.exp_beats - 1});
          last_tag = out_tag;
          beats++;
          if (out_last) finishing = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    check({v.name, " completed within budget"}, {31'd0, finished}, 32'd1);
    check({v.name, " beat count"}, beats, v.exp_beats);
    check({v.name, " last tag"}, {30'd0, last_tag}, {30'd0, v.exp_last_tag});
    #1;
    check({v.name, " done is one cycle"}, {31'd0, done}, 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{"basic",        16'h3000, 16'd3, 0, -1, -1, 12, 2'd2};
    vecs[1] = '{"backpressure", 16'h3000, 16'd3, 1, -1, -1, 12, 2'd2};
    vecs[2] = '{"count0",       16'h3000, 16'd0, 0, -1, -1,  9, 2'd1};
    vecs[3] = '{"wrap",         16'hFFFF, 16'd2, 0, -1, -1, 11, 2'd2};
    vecs[4] = '{"start_busy",   16'h3000, 16'd3, 0,  4, -1, 12, 2'd2};
    vecs[5] = '{"count0_bp",    16'h3000, 16'd0, 1, -1, -1,  9, 2'd1};
    vecs[6] = '{"one_mem_bp",   16'h0100, 16'd1, 1, -1, -1, 10, 2'd2};

    rst       = 1'b1;
    start     = 1'b0;
    mem_base  = '0;
    mem_count = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset outputs", {out_valid, out_last, busy, done, out_tag, rf_debug_addr},
          32'd0);
    check("reset data", {out_data, mem_debug_addr}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("idle no valid", {30'd0, out_valid, busy}, 32'd0);
    end

    for (int i = 0; i < 7; i++) run_dump(vecs[i]);

    // Reset during beat 6 aborts, then a fresh dump works.
    run_dump('{"rst_mid", 16'h3000, 16'd3, 0, -1, 5, 12, 2'd2});
    run_dump(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
